fc_feature_streamer: RTL and testbench

//  Producer side of the fully-connected stage. Collects the flattened int8 feature

---
 rtl/fc_pkg.sv | 12 +
 rtl/fc_feat_buf.sv | 28 ++
 rtl/fc_feature_streamer.sv | 128 ++++++++++++
 tb/tb_fc_feature_streamer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared sizes, lane type and FSM states for the FC feature streamer
package fc_pkg;

   localparam int FC_LANES  = 4;
   localparam int FC_DW     = 8;
   localparam int FC_N_FEAT = 64;

   typedef logic signed [FC_DW-1:0] fc_lane_t;

   typedef enum logic [1:0] {FILL, STREAM, WAIT, CLEAR} fc_state_t;

endpackage

// File: rtl/fc_feat_buf.sv
// fc_feat_buf: N_FEAT x DW feature register file, one write per cycle, one beat of lanes read out
module fc_feat_buf #(
   parameter int N_FEAT = 64,
   parameter int LANES  = 4,
   parameter int DW     = 8
) (
   input  logic                                 clk,
   input  logic                                 we_i,
   input  logic [$clog2(N_FEAT)-1:0]            waddr_i,
   input  logic [DW-1:0]                        wdata_i,
   input  logic [$clog2(N_FEAT/LANES)-1:0]      beat_i,
   output logic [LANES-1:0][DW-1:0]             lanes_o
);

   localparam int AW = $clog2(N_FEAT);

   logic [DW-1:0] mem_q [N_FEAT];

   // store each accepted feature at its frame position
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lanes_o[l] = mem_q[AW'(beat_i) * AW'(LANES) + AW'(l)];
   end

endmodule

// File: rtl/fc_feature_streamer.sv
// fc_feature_streamer: buffers one feature frame and streams it to the FC, then collects the class
module fc_feature_streamer
   import fc_pkg::*;
#(
   parameter int N_FEAT       = FC_N_FEAT,
   parameter int LANES        = FC_LANES,
   parameter int DW           = FC_DW,
   parameter int FLAG_TIMEOUT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  feat_valid_i,
   input  logic [DW-1:0]         feat_data_i,
   input  logic                  feat_last_i,
   output logic                  feat_ready_o,
   output logic                  fc_en_o,
   output logic [LANES*DW-1:0]   fc_in_o,
   input  logic                  fc_flag_i,
   input  logic [1:0]            fc_class_i,
   output logic [1:0]            class_out_o,
   output logic                  class_valid_o,
   output logic                  frame_err_o
);

   localparam int BEATS = N_FEAT / LANES;
   localparam int AW    = $clog2(N_FEAT);
   localparam int BW    = $clog2(BEATS);
   localparam int TW    = $clog2(FLAG_TIMEOUT + 1);

   fc_state_t                 st_q;
   logic [AW-1:0]             wr_idx_q;
   logic [BW-1:0]             beat_q, beat_d, rd_beat;
   logic [TW-1:0]             to_q;
   logic                      feat_ready_q, fc_en_q, class_valid_q, frame_err_q;
   logic [1:0]                class_q;
   logic [LANES-1:0][DW-1:0]  fc_in_q, rd_lanes;
   logic                      accept, last_idx;

   assign accept   = feat_valid_i && feat_ready_q;
   assign last_idx = wr_idx_q == AW'(N_FEAT - 1);
   assign beat_d   = beat_q + 1'b1;
   // beat 0 is fetched on the accepting edge so the first STREAM cycle already carries it
   assign rd_beat  = (st_q == STREAM) ? beat_d : '0;

   fc_feat_buf #(.N_FEAT(N_FEAT), .LANES(LANES), .DW(DW)) u_buf (
      .clk     (clk),
      .we_i    (accept),
      .waddr_i (wr_idx_q),
      .wdata_i (feat_data_i),
      .beat_i  (rd_beat),
      .lanes_o (rd_lanes)
   );

   // frame FSM with counters and registered FC-side outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q          <= FILL;
         wr_idx_q      <= '0;
         beat_q        <= '0;
         to_q          <= '0;
         feat_ready_q  <= 1'b1;
         fc_en_q       <= 1'b0;
         fc_in_q       <= '0;
         class_q       <= '0;
         class_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         class_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         case (st_q)
            FILL: begin
               if (accept) begin
                  if (feat_last_i && last_idx) begin
                     st_q         <= STREAM;
                     wr_idx_q     <= '0;
                     beat_q       <= '0;
                     feat_ready_q <= 1'b0;
                     fc_en_q      <= 1'b1;
                     fc_in_q      <= rd_lanes;
                  end else if (feat_last_i || last_idx) begin
                     frame_err_q <= 1'b1;
                     wr_idx_q    <= '0;
                  end else begin
                     wr_idx_q <= wr_idx_q + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (beat_q == BW'(BEATS - 1)) begin
                  st_q    <= WAIT;
                  fc_in_q <= '0;
                  to_q    <= '0;
               end else begin
                  beat_q  <= beat_d;
                  fc_in_q <= rd_lanes;
               end
            end
            WAIT: begin
               if (fc_flag_i) begin
                  class_q       <= fc_class_i;
                  class_valid_q <= 1'b1;
                  fc_en_q       <= 1'b0;
                  st_q          <= CLEAR;
               end else if (to_q == TW'(FLAG_TIMEOUT - 1)) begin
                  frame_err_q <= 1'b1;
                  fc_en_q     <= 1'b0;
                  st_q        <= CLEAR;
               end else begin
                  to_q <= to_q + 1'b1;
               end
            end
            CLEAR: begin
               feat_ready_q <= 1'b1;
               st_q         <= FILL;
            end
            default: st_q <= FILL;
         endcase
      end
   end

   assign feat_ready_o  = feat_ready_q;
   assign fc_en_o       = fc_en_q;
   assign fc_in_o       = fc_in_q;
   assign class_out_o   = class_q;
   assign class_valid_o = class_valid_q;
   assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_fc_feature_streamer.sv
// tb_fc_feature_streamer: scoreboard bench with an FC model for the feature streamer
module tb_fc_feature_streamer;
   import fc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        feat_valid = 1'b0;
   logic        feat_last = 1'b0;
   fc_lane_t    feat_data = '0;
   logic        feat_ready, fc_en, fc_flag, class_valid, frame_err;
   logic [31:0] fc_in;
   logic [1:0]  fc_class, class_out;

   int          total = 0;
   int          bad = 0;
   bit          flag_en = 1'b1;
   logic [1:0]  fc_cls = 2'd1;
   int          fc_cnt = 0;

   typedef struct {int kind; logic [31:0] val;} ev_t;
   ev_t      q[$];
   fc_lane_t fv[64];

   always #5 clk = ~clk;

   fc_feature_streamer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .feat_valid_i  (feat_valid),
      .feat_data_i   (feat_data),
      .feat_last_i   (feat_last),
      .feat_ready_o  (feat_ready),
      .fc_en_o       (fc_en),
      .fc_in_o       (fc_in),
      .fc_flag_i     (fc_flag),
      .fc_class_i    (fc_class),
      .class_out_o   (class_out),
      .class_valid_o (class_valid),
      .frame_err_o   (frame_err)
   );

   // FC model: counts enabled cycles, raises done one cycle after the 16th beat
   always @(posedge clk) fc_cnt <= fc_en ? fc_cnt + 1 : 0;
   assign fc_flag  = flag_en && fc_en && fc_cnt == 16;
   assign fc_class = fc_cls;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // monitor: every enabled cycle, class pulse or error pulse is one scoreboard event
   always @(negedge clk) begin
      ev_t o, e;
      if (fc_en || class_valid || frame_err) begin
         o.kind = fc_en ? 0 : class_valid ? 1 : 2;
         o.val  = fc_en ? fc_in : class_valid ? {30'd0, class_out} : 32'd0;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: kind=%0d val=%0h want none", o.kind, o.val);
         end else begin
            e = q.pop_front();
            chk("event_kind", o.kind, e.kind);
            chk("event_val", o.val, e.val);
            if (class_valid) chk("clear_ready", {31'd0, feat_ready}, 32'd0);
         end
      end
   end

   task automatic fill(input int mul, input int off);
      for (int k = 0; k < 64; k++) fv[k] = fc_lane_t'(mul * (k + 1) + off);
   endtask

   task automatic push_frame(input int nb, input int nz, input int tail, input logic [1:0] c);
      for (int b = 0; b < nb; b++) begin
         logic [31:0] w;
         for (int l = 0; l < 4; l++) w[l*8 +: 8] = fv[b*4 + l];
         q.push_back('{0, w});
      end
      for (int i = 0; i < nz; i++) q.push_back('{0, 32'd0});
      if (tail == 1) q.push_back('{1, {30'd0, c}});
      else if (tail == 2) q.push_back('{2, 32'd0});
   endtask

   task automatic put(input fc_lane_t d, input bit l);
      int w = 0;
      feat_valid = 1'b1;
      feat_data  = d;
      feat_last  = l;
      while (!feat_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) begin
         total++;
         bad++;
         $display("FAIL put_timeout: ready=%0b want 1", feat_ready);
      end
      @(negedge clk);
      feat_valid = 1'b0;
      feat_last  = 1'b0;
   endtask

   task automatic send(input int n, input int last_at);
      for (int k = 0; k < n; k++) put(fv[k], k == last_at - 1);
   endtask

   task automatic drain();
      int w = 0;
      while (q.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d want 0", q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_fc_en", {31'd0, fc_en}, 32'd0);
      chk("rst_ready", {31'd0, feat_ready}, 32'd1);
      chk("rst_class_valid", {31'd0, class_valid}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_class_out", {30'd0, class_out}, 32'd0);
      chk("rst_fc_in", fc_in, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      fill(1, 0);
      push_frame(16, 1, 1, 2'd1);
      send(64, 64);
      drain();
      chk("class_after_frame1", {30'd0, class_out}, 32'd1);
      chk("ready_after_frame1", {31'd0, feat_ready}, 32'd1);

      fill(-1, 0);
      q.push_back('{2, 32'd0});
      send(10, 10);
      drain();
      chk("ready_after_short", {31'd0, feat_ready}, 32'd1);
      fill(2, -65);
      fc_cls = 2'd2;
      push_frame(16, 1, 1, 2'd2);
      send(64, 64);
      drain();
      chk("class_after_recover", {30'd0, class_out}, 32'd2);

      flag_en = 1'b0;
      fill(1, 10);
      push_frame(16, 8, 2, 2'd0);
      send(64, 64);
      drain();
      chk("class_kept_on_timeout", {30'd0, class_out}, 32'd2);
      chk("ready_after_timeout", {31'd0, feat_ready}, 32'd1);

      flag_en = 1'b1;
      fc_cls = 2'd3;
      fill(1, -32);
      push_frame(8, 0, 0, 2'd0);
      send(64, 64);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_fc_en", {31'd0, fc_en}, 32'd0);
      chk("midrst_ready", {31'd0, feat_ready}, 32'd1);
      chk("midrst_class_valid", {31'd0, class_valid}, 32'd0);
      chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("midrst_pending", q.size(), 32'd0);
      rst_n = 1'b1;
      push_frame(16, 1, 1, 2'd3);
      send(64, 64);
      drain();
      chk("class_after_midrst", {30'd0, class_out}, 32'd3);

      fc_cls = 2'd1;
      fill(-1, 0);
      push_frame(16, 1, 1, 2'd1);
      send(64, 64);
      fill(1, 20);
      push_frame(16, 1, 1, 2'd1);
      send(64, 64);
      drain();
      chk("class_after_b2b", {30'd0, class_out}, 32'd1);
      chk("ready_after_b2b", {31'd0, feat_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
